// File: rtl/posit_pkg.sv
// Shared posit encoder definitions: geometry, special encodings and the
// decoded-field bundle carried through the first pipeline stage.
package posit_pkg;

  // Ceiling log2, used to size the regime-run field.
  function automatic int unsigned log2(input int unsigned x);
    int unsigned r;
    logic [32:0] p;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      p = 33'(1) << i;
      if (p < 33'(x)) r = unsigned'(i + 1);
    end
    return r;
  endfunction

  localparam int unsigned N  = 16;
  localparam int unsigned ES = 2;
  localparam int unsigned BS = log2(N);
  localparam int unsigned SW = BS + ES + 2;
  localparam int unsigned FW = N - ES;      // fraction width below the hidden bit
  localparam int unsigned MW = N - 1;       // magnitude width (posit minus sign)

  localparam int MAXSCALE = int'((N - 2) << ES);

  localparam logic [N-1:0] NAR_PATTERN = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXPOS      = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS      = N'(1);

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 nar;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
  } posit_fields_t;

endpackage

// File: rtl/posit_encode_pipe_if.sv
// Handshake bus of the posit encoder: input beat (fields) and output posit.
//   in_valid/in_ready  : input beat handshake
//   in_sign/zero/nar   : sign and special-value flags
//   in_scale/in_frac   : signed combined scale and MSB-aligned fraction
//   out_valid/out_ready: output handshake
//   out_posit          : encoded posit
interface posit_encode_pipe_if;
  import posit_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic                 in_zero;
  logic                 in_nar;
  logic signed [SW-1:0] in_scale;
  logic [FW-1:0]        in_frac;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_posit;

  modport slave (
    input  in_valid, in_sign, in_zero, in_nar, in_scale, in_frac, out_ready,
    output in_ready, out_valid, out_posit
  );

  modport master (
    output in_valid, in_sign, in_zero, in_nar, in_scale, in_frac, out_ready,
    input  in_ready, out_valid, out_posit
  );

endinterface

// File: rtl/posit_round_ne.sv
// Round-to-nearest-even of a posit magnitude, clamped to [minpos, maxpos].
//   mag       : truncated magnitude (posit without sign bit)
//   guard     : first discarded bit
//   sticky    : OR of all bits below guard
//   rounded_c : rounded, clamped magnitude (combinational)
module posit_round_ne
  import posit_pkg::*;
(
  input  logic [MW-1:0] mag,
  input  logic          guard,
  input  logic          sticky,
  output logic [MW-1:0] rounded_c
);

  logic          inc_c;
  logic [MW:0]   sum_c;

  always_comb begin
    inc_c     = guard & (mag[0] | sticky);
    sum_c     = {1'b0, mag} + (MW+1)'(inc_c);
    // A carry out would spill into the sign bit: hold at maxpos instead.
    rounded_c = sum_c[MW] ? MAXPOS[MW-1:0] : sum_c[MW-1:0];
    if (rounded_c == '0) rounded_c = MINPOS[MW-1:0];
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Three-stage posit encoder: packs sign, scale, fraction and special flags
// into an N-bit posit with round-to-nearest-even.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of posit_encode_pipe_if (input beat in, posit out)
module posit_encode_pipe
  import posit_pkg::*;
(
  input logic                clk,
  input logic                reset,
  posit_encode_pipe_if.slave bus
);

  localparam logic signed [SW-1:0] SCALE_HI = SW'(MAXSCALE);
  localparam logic signed [SW-1:0] SCALE_LO = SW'(-MAXSCALE);
  localparam int unsigned          PAD      = 2*N - 2 - ES - FW;

  logic en_c;

  // S1 state
  logic          s1_valid;
  posit_fields_t s1_f;
  logic          s1_sat_hi;
  logic          s1_sat_lo;

  // S2 state
  logic          s2_valid;
  logic          s2_sign;
  logic          s2_zero;
  logic          s2_nar;
  logic          s2_sat_hi;
  logic          s2_sat_lo;
  logic [MW-1:0] s2_mag;
  logic          s2_guard;
  logic          s2_sticky;

  // S3 state
  logic          s3_valid;
  logic [N-1:0]  s3_posit;

  // Combinational stage logic
  posit_fields_t          in_f_c;
  logic signed [SW-1:0]   k_c;
  logic [SW-1:0]          shamt_c;
  logic signed [2*N-1:0]  vec_pre_c;
  logic signed [2*N-1:0]  vec_c;
  logic [MW-1:0]          rnd_c;
  logic [MW-1:0]          mag_sel_c;
  logic [N-1:0]           posit_c;

  // Whole pipe advances together unless the output is holding a beat.
  assign en_c          = !s3_valid || bus.out_ready;
  assign bus.in_ready  = en_c;
  assign bus.out_valid = s3_valid;
  assign bus.out_posit = s3_posit;

  // S1 input bundling
  always_comb begin
    in_f_c       = '0;
    in_f_c.sign  = bus.in_sign;
    in_f_c.zero  = bus.in_zero;
    in_f_c.nar   = bus.in_nar;
    in_f_c.scale = bus.in_scale;
    in_f_c.frac  = bus.in_frac;
  end

  // S2 assembly: a two-bit regime seed {run bit, terminator} followed by
  // exponent and fraction, arithmetic-shifted so the run bit replicates.
  // k >= 0 shifts by k (k+1 ones); k < 0 shifts by -k-1 = ~k (-k zeros).
  always_comb begin
    k_c       = s1_f.scale >>> ES;
    shamt_c   = k_c[SW-1] ? ~k_c : k_c;
    vec_pre_c = {(k_c[SW-1] ? 2'b01 : 2'b10), s1_f.scale[ES-1:0], s1_f.frac,
                 {PAD{1'b0}}};
    vec_c     = vec_pre_c >>> shamt_c;
  end

  posit_round_ne u_round (
    .mag       (s2_mag),
    .guard     (s2_guard),
    .sticky    (s2_sticky),
    .rounded_c (rnd_c)
  );

  // S3 special-case priority, saturation and sign application
  always_comb begin
    mag_sel_c = rnd_c;
    if (s2_sat_hi)      mag_sel_c = MAXPOS[MW-1:0];
    else if (s2_sat_lo) mag_sel_c = MINPOS[MW-1:0];
    posit_c = {1'b0, mag_sel_c};
    if (s2_nar)         posit_c = NAR_PATTERN;
    else if (s2_zero)   posit_c = '0;
    else if (s2_sign)   posit_c = N'(0) - {1'b0, mag_sel_c};
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_f      <= '0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_nar    <= 1'b0;
      s2_sat_hi <= 1'b0;
      s2_sat_lo <= 1'b0;
      s2_mag    <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s3_valid  <= 1'b0;
      s3_posit  <= '0;
    end else if (en_c) begin
      s1_valid  <= bus.in_valid;
      s1_f      <= in_f_c;
      s1_sat_hi <= bus.in_scale > SCALE_HI;
      s1_sat_lo <= bus.in_scale < SCALE_LO;

      s2_valid  <= s1_valid;
      s2_sign   <= s1_f.sign;
      s2_zero   <= s1_f.zero;
      s2_nar    <= s1_f.nar;
      s2_sat_hi <= s1_sat_hi;
      s2_sat_lo <= s1_sat_lo;
      s2_mag    <= vec_c[2*N-1 -: MW];
      s2_guard  <= vec_c[N];
      s2_sticky <= |vec_c[N-1:0];

      s3_valid  <= s2_valid;
      s3_posit  <= posit_c;
    end
  end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Bench for posit_encode_pipe: bit-string reference model, scoreboard,
// hold-stability and ready-rule monitor, latency and mid-flight reset checks.
module tb_posit_encode_pipe;
  import posit_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   ready_mode = 1'b0;

  logic [15:0] exp_q[$];
  bit          hold_valid = 1'b0;
  logic [15:0] hold_posit;

  posit_encode_pipe_if bus();

  posit_encode_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: spell out the posit as a bit string, then round on integers.
  function automatic logic [15:0] model(input posit_fields_t f);
    int sc, k, e, mag, fr;
    bit b[$];
    bit g, s;
    sc = f.scale;
    fr = f.frac;
    if (f.nar)  return 16'h8000;
    if (f.zero) return 16'h0000;
    if (sc > 56)       mag = 32767;
    else if (sc < -56) mag = 1;
    else begin
      k = (sc >= 0) ? sc / 4 : -((3 - sc) / 4);
      e = sc - 4 * k;
      if (k >= 0) begin
        repeat (k + 1) b.push_back(1'b1);
        b.push_back(1'b0);
      end else begin
        repeat (-k) b.push_back(1'b0);
        b.push_back(1'b1);
      end
      for (int i = 1; i >= 0; i--) b.push_back(((e >> i) & 1) != 0);
      for (int i = 13; i >= 0; i--) b.push_back(((fr >> i) & 1) != 0);
      mag = 0;
      for (int i = 0; i < 15; i++) mag = mag * 2 + int'(b[i]);
      g = b[15];
      s = 1'b0;
      for (int i = 16; i < b.size(); i++) s = s | b[i];
      if (g && ((mag % 2) == 1 || s)) mag++;
      if (mag > 32767) mag = 32767;
      if (mag == 0) mag = 1;
    end
    return f.sign ? 16'(65536 - mag) : 16'(mag);
  endfunction

  function automatic posit_fields_t mk(input bit sg, input bit z, input bit n, input int sc, input int fr);
    posit_fields_t f;
    f.sign  = sg;
    f.zero  = z;
    f.nar   = n;
    f.scale = SW'(sc);
    f.frac  = FW'(fr);
    return f;
  endfunction

  // Output readiness: constant 1 or random per cycle.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard, hold stability and ready rule, sampled mid-cycle.
  always @(negedge clk) begin
    posit_fields_t f;
    if (reset) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (hold_valid) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_posit", bus.out_posit, hold_posit);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got 0x%0h expected no beat", bus.out_posit);
        end else begin
          check("out_posit", bus.out_posit, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        f = mk(bus.in_sign, bus.in_zero, bus.in_nar, int'(bus.in_scale), int'(bus.in_frac));
        exp_q.push_back(model(f));
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_posit = bus.out_posit;
    end
  end

  task automatic drive(input posit_fields_t f);
    bus.in_sign  = f.sign;
    bus.in_zero  = f.zero;
    bus.in_nar   = f.nar;
    bus.in_scale = f.scale;
    bus.in_frac  = f.frac;
    bus.in_valid = 1'b1;
  endtask

  // Present a beat until accepted; returns just after the accepting edge.
  task automatic send(input posit_fields_t f);
    bit hs = 1'b0;
    int n = 0;
    drive(f);
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Single beat into an empty, unstalled pipe: out_valid after 3 edges.
  task automatic send_timed(input posit_fields_t f, input string name);
    int lat = 0;
    drive(f);
    @(negedge clk);
    check({name, "_accept"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    idle();
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check({name, "_latency"}, lat, 3);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  posit_fields_t pin_f[16];
  logic [15:0]   pin_e[16];

  initial begin
    posit_fields_t f;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_zero  = 1'b0;
    bus.in_nar   = 1'b0;
    bus.in_scale = '0;
    bus.in_frac  = '0;

    pin_f[0]  = mk(0, 0, 0,    0, 14'h0000); pin_e[0]  = 16'h4000;
    pin_f[1]  = mk(1, 0, 0,    0, 14'h0000); pin_e[1]  = 16'hC000;
    pin_f[2]  = mk(0, 0, 0,    1, 14'h0000); pin_e[2]  = 16'h4800;
    pin_f[3]  = mk(0, 0, 0,    4, 14'h0000); pin_e[3]  = 16'h6000;
    pin_f[4]  = mk(0, 0, 0,    0, 14'h2000); pin_e[4]  = 16'h4400;
    pin_f[5]  = mk(0, 0, 0,    0, 14'h0004); pin_e[5]  = 16'h4000;
    pin_f[6]  = mk(0, 0, 0,    0, 14'h000C); pin_e[6]  = 16'h4002;
    pin_f[7]  = mk(0, 0, 0,    0, 14'h0005); pin_e[7]  = 16'h4001;
    pin_f[8]  = mk(0, 0, 0,  100, 14'h0000); pin_e[8]  = 16'h7FFF;
    pin_f[9]  = mk(0, 0, 0, -100, 14'h0000); pin_e[9]  = 16'h0001;
    pin_f[10] = mk(1, 0, 0,  100, 14'h0000); pin_e[10] = 16'h8001;
    pin_f[11] = mk(1, 0, 0, -100, 14'h0000); pin_e[11] = 16'hFFFF;
    pin_f[12] = mk(0, 0, 0,   56, 14'h0000); pin_e[12] = 16'h7FFF;
    pin_f[13] = mk(1, 0, 1,   -7, 14'h1234); pin_e[13] = 16'h8000;
    pin_f[14] = mk(1, 1, 0,   12, 14'h3FFF); pin_e[14] = 16'h0000;
    pin_f[15] = mk(0, 1, 1,    3, 14'h0001); pin_e[15] = 16'h8000;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_posit", bus.out_posit, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Hand-computed encodings pin the model; the DUT is checked via scoreboard.
    for (int i = 0; i < 16; i++)
      check($sformatf("pin%0d", i), model(pin_f[i]), pin_e[i]);
    send_timed(pin_f[0], "first");
    drain();
    for (int i = 1; i < 16; i++) send(pin_f[i]);
    idle();
    drain();

    // Random beats under random back-pressure.
    ready_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      f.sign  = 1'($urandom_range(0, 1));
      f.zero  = ($urandom_range(0, 15) == 0);
      f.nar   = ($urandom_range(0, 15) == 0);
      f.scale = SW'($urandom);
      if ($urandom_range(0, 1) == 1) f.scale = SW'($urandom_range(0, 112)) - SW'(56);
      f.frac  = FW'($urandom);
      send(f);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    drain();
    ready_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset with three beats in flight.
    send(mk(0, 0, 0, 8, 14'h0100));
    send(mk(1, 0, 0, -3, 14'h0200));
    send(mk(0, 0, 0, 20, 14'h0300));
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send_timed(mk(0, 0, 0, -9, 14'h2AAA), "post_rst");
    drain();
    repeat (10) @(negedge clk);
    check("final_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_encode_pipe.md
Name: posit_encode_pipe

Overview:
Pipelined posit encoder: packs sign, combined scale (regime·2^es + exponent), fraction and zero/NaR flags into an N-bit posit with round-to-nearest-even. It is the inverse of the posit field-extraction logic and feeds results from the PairHMM posit datapath back into stream output and accumulator registers. Valid/ready handshake on both sides; fixed 3-stage pipeline.

Parameters:
N, 16, posit width in bits
ES, 2, exponent field width
BS, log2(N), regime-run-length width (4 for N=16)
SW, BS+ES+2, signed scale width (8 for defaults)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  encoder can accept a beat
in_sign  in  1  sign of value
in_zero  in  1  value is exact zero (dominates all fields except in_nar)
in_nar  in  1  value is NaR (dominates everything)
in_scale  in  SW  signed scale = k·2^ES + e
in_frac  in  N-ES  fraction below the hidden bit, MSB-aligned
out_valid  out  1  output posit valid
out_ready  in  1  downstream accepts
out_posit  out  N  encoded posit, two's complement for negatives

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-high. On reset: all stage valids = 0, out_valid = 0, out_posit = 0. Reset mid-flight discards all in-flight beats; in_ready = 1 in the first cycle after reset deasserts.
- Pipeline: S1 input register + saturation; S2 regime/exponent/fraction assembly and shift; S3 rounding, clamp, negation → out_posit. Latency 3 cycles from accepted beat to out_valid when unstalled; throughput 1/cycle.
- Stall: en = !s3_valid | out_ready; all stages advance only when en; in_ready = en. Bubbles are not collapsed. While out_valid & !out_ready, out_posit holds stable.
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready. Simultaneous output pop and input push in one cycle is permitted.
- Special cases: in_nar → 1 followed by N-1 zeros (0x8000). Else in_zero → 0. in_sign is ignored for both.
- Saturation (S1): maxscale = (N-2)·2^ES (56). scale > maxscale → magnitude maxpos (0x7FFF). scale < -maxscale → minpos (0x0001). Never rounds to 0 or NaR.
- Regime: k = scale >>> ES (arithmetic), e = scale[ES-1:0]. k ≥ 0: k+1 ones then a 0. k < 0: -k zeros then a 1.
- Assembly: concatenate {regime, e, in_frac} into a 2N-bit vector, left-aligned. The top N-1 bits form the magnitude. Guard = next bit. Sticky = OR of all remaining bits.
- Rounding: increment the magnitude if guard & (lsb | sticky). Clamp the result to [0x0001, 0x7FFF]; the increment must not carry into the sign bit.
- Negation: in_sign = 1 → out_posit = two's complement of {0, magnitude}.

Decomposition:
- Package posit_pkg holds:
  - log2 function;
  - posit_fields_t struct (sign, zero, nar, scale, frac);
  - constants NAR_PATTERN, MAXPOS, MINPOS and MAXSCALE, as functions of N and ES.
- One sub-module, posit_round_ne: combinational N-1-bit magnitude + guard + sticky → rounded, clamped magnitude. Instantiated in S3.

Test Plan:
- 1.0 (sign 0, scale 0, frac 0) → 0x4000 after exactly 3 cycles. Sign 1 → 0xC000. Scale 1 → 0x4800. Scale 4 → 0x6000. frac 14'h2000 (1.5) → 0x4400.
- Rounding: scale 0, frac 14'h0004 (tie, lsb 0) → 0x4000. frac 14'h000C (tie, lsb 1) → 0x4002. frac 14'h0005 (above half) → 0x4001.
- Saturation: scale 100 → 0x7FFF. Scale -100 → 0x0001. Same with sign 1 → 0x8001 and 0xFFFF. Scale 56 → 0x7FFF.
- Specials: in_nar with any fields → 0x8000. in_zero, sign 1 → 0x0000. in_nar and in_zero both set → 0x8000.
- Back-pressure: stream 8 beats with out_ready toggling randomly. Check in-order output, no loss or duplication, out_posit stable while stalled, and in_ready low only when s3 is full and out_ready is low.
- Reset mid-flight: 3 beats in flight, assert reset 1 cycle → out_valid = 0 next cycle, no stale beat emerges afterwards, next accepted beat appears after 3 cycles.
